instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   Fetch sequencer that feeds the decode FSM. Owns the PC, issues one word
//   read per instruction over a req/ack memory handshake, presents the word on
//   a valid/ready port, and handles taken branches, halt and memory timeouts.
//   Sits between the instruction memory and the decode FSM's instr_set input.
// PARAMETERS
//   ADDR_W    16      PC / memory address width (word addressed)
//   RESET_PC  16'h0   PC value loaded on reset
//   MAX_WAIT  15      cycles in WAIT without mem_ack before timeout (1..255)
// PORTS
//   clk            in   1       clock, all state updates on rising edge
//   reset          in   1       asynchronous, active-high reset
//   halt           in   1       1 = do not start new fetches
//   branch_en      in   1       1-cycle pulse: redirect PC to branch_target
//   branch_target  in   ADDR_W  new PC when branch_en=1
//   mem_req        out  1       read request, held high until mem_ack
//   mem_addr       out  ADDR_W  read address, stable while mem_req=1
//   mem_ack        in   1       read data valid this cycle (sampled when mem_req=1)
//   mem_rdata      in   16      instruction word
//   instr_out      out  16      fetched instruction to decode
//   instr_valid    out  1       instr_out valid
//   instr_ready    in   1       decode accepts instr_out this cycle
//   pc_out         out  ADDR_W  address of next fetch
//   timeout_err    out  1       sticky: a fetch timed out
//   fetch_count    out  16      completed fetches (FETCH_PERF_CNT_EN)
//   stall_count    out  16      cycles with instr_valid=1 & instr_ready=0
// BEHAVIOUR
//   Reset: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, instr_out=0,
//     instr_valid=0, timeout_err=0, counters=0, wait_cnt=0, discard=0.
//   All outputs registered. States IDLE, WAIT, HOLD.
//   IDLE: halt=0 -> WAIT, mem_req<=1, mem_addr<=pc, wait_cnt<=0. halt=1 -> stay.
//   WAIT: mem_req=1. On mem_ack & !discard: mem_req<=0, instr_out<=mem_rdata,
//     instr_valid<=1, pc<=pc+1 (wraps all-ones -> 0), -> HOLD.
//     On mem_ack & discard: data dropped, mem_req<=0, discard<=0, -> IDLE.
//     No ack: wait_cnt++; when wait_cnt==MAX_WAIT: mem_req<=0, timeout_err<=1,
//     -> IDLE (retries same pc). Ack on the timeout cycle wins (no error).
//   HOLD: instr_valid=1, instr_out stable. On instr_ready: instr_valid<=0;
//     halt=0 -> WAIT with mem_req<=1, mem_addr<=pc (back-to-back, one
//     instruction per 2 cycles with zero-wait memory); halt=1 -> IDLE.
//   Latency: first mem_req 1 cycle after first edge with reset low; mem_ack
//     -> instr_valid next edge.
//   Branch (branch_en=1), priority over all other events:
//     IDLE/HOLD: pc<=branch_target, instr_valid<=0 (held word dropped even if
//       instr_ready same cycle), -> IDLE.
//     WAIT: pc<=branch_target; req must not drop before ack, so discard<=1 and
//       stay in WAIT; if mem_ack same cycle, data dropped, mem_req<=0, -> IDLE.
//     Branch during discard: pc updated again, discard stays 1.
//   Halt never aborts a request in flight; the word is still presented.
//   Reset mid-operation: immediate return to reset values; mem_req drops
//     asynchronously; memory must tolerate the aborted request.
//   timeout_err clears only on reset.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: fetch_count increments on each non-discarded
//     mem_ack; stall_count increments each cycle instr_valid=1 & instr_ready=0;
//     both 16-bit, saturate at 16'hFFFF.
//   Not defined: counters not built; fetch_count and stall_count tied to 0.
// TESTING
//   Zero-wait memory returning addr^16'hA5A5, instr_ready=1, RESET_PC=0 ->
//     instr_out sequence 16'hA5A5,16'hA5A4,16'hA5A7; new instr every 2 cycles.
//   instr_ready=0 for 5 cycles in HOLD -> instr_out stable, no mem_req,
//     stall_count=5 (macro on), 0 (macro off).
//   branch_en, target=16'h0040, during WAIT; ack 3 cycles later with 16'h1234
//     -> 16'h1234 never valid; next mem_addr=16'h0040.
//   mem_ack never asserted -> mem_req drops after MAX_WAIT=15 cycles,
//     timeout_err=1, new request at same addr, error stays 1.
//   halt=1 while in WAIT -> word delivered, after accept state IDLE,
//     mem_req=0; halt=0 -> mem_req next cycle at pc+1.
//   reset pulse while mem_req=1 -> mem_req=0, instr_valid=0, pc_out=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl_if
//  Description : Bundles the request/acknowledge memory port, the valid/ready
//                decode port, the control inputs (halt, branch) and the
//                status outputs of the instruction fetch controller.
//                master : the fetch controller side
//                slave  : the environment side (memory, decode, control)
//  Ports       : halt, branch_en, branch_target     control into the fetcher
//                mem_req, mem_addr, mem_ack, mem_rdata   memory handshake
//                instr_out, instr_valid, instr_ready     decode handshake
//                pc_out, timeout_err, fetch_count, stall_count   status
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              halt;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [15:0]       instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc_out;
  logic              timeout_err;
  logic [15:0]       fetch_count;
  logic [15:0]       stall_count;

  modport master (
    input  halt, branch_en, branch_target, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_out, instr_valid, pc_out, timeout_err,
           fetch_count, stall_count
  );

  modport slave (
    output halt, branch_en, branch_target, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_out, instr_valid, pc_out, timeout_err,
           fetch_count, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Instruction fetch sequencer. Owns the PC, issues one word
//                read per instruction over a req/ack memory handshake, holds
//                the fetched word on a valid/ready port for decode, and
//                handles taken branches, halt and memory timeouts.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - instr_fetch_ctrl_if.master (memory, decode, control
//                         and status signals)
//  Config      : FETCH_PERF_CNT_EN - when defined, builds saturating 16-bit
//                fetch and stall counters; otherwise both read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  wire logic           clk,
  input  wire logic           reset,
  instr_fetch_ctrl_if.master  bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  localparam logic [8:0]        c_MAX_WAIT = 9'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] c_PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_mem_req;
  logic              w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [15:0]       r_instr_out;
  logic [15:0]       w_instr_out_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic              r_timeout_err;
  logic              w_timeout_err_nxt;
  logic              r_discard;
  logic              w_discard_nxt;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_wait_cnt_nxt;
  logic [8:0]        w_wait_inc;
  logic              w_timeout;

  // Count of WAIT cycles including the current one; the request is abandoned
  // once this reaches MAX_WAIT without an acknowledge.
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
  assign w_timeout  = (w_wait_inc >= c_MAX_WAIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A branch always wins, but in WAIT the request cannot be
  // withdrawn until the memory acknowledges, so the FSM stays in WAIT and
  // marks the outstanding word for discard instead.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (!bus.branch_en && !bus.halt) begin
          w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        if (bus.mem_ack) begin
          w_state_nxt = (r_discard || bus.branch_en) ? c_IDLE : c_HOLD;
        end else if (!bus.branch_en && w_timeout) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_HOLD: begin
        if (bus.branch_en) begin
          w_state_nxt = c_IDLE;
        end else if (bus.instr_ready) begin
          w_state_nxt = bus.halt ? c_IDLE : c_WAIT;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt          = r_pc;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_out_nxt   = r_instr_out;
    w_instr_valid_nxt = r_instr_valid;
    w_timeout_err_nxt = r_timeout_err;
    w_discard_nxt     = r_discard;
    w_wait_cnt_nxt    = r_wait_cnt;
    case (r_state)
      c_IDLE: begin
        if (bus.branch_en) begin
          w_pc_nxt          = bus.branch_target;
          w_instr_valid_nxt = 1'b0;
        end else if (!bus.halt) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
          w_wait_cnt_nxt = 8'd0;
        end
      end
      c_WAIT: begin
        if (bus.branch_en) begin
          w_pc_nxt = bus.branch_target;
        end
        if (bus.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (r_discard || bus.branch_en) begin
            w_discard_nxt = 1'b0;
          end else begin
            w_instr_out_nxt   = bus.mem_rdata;
            w_instr_valid_nxt = 1'b1;
            w_pc_nxt          = r_pc + c_PC_ONE;
          end
        end else begin
          // Saturate so a long run of branches cannot wrap the counter.
          if (r_wait_cnt != 8'hFF) begin
            w_wait_cnt_nxt = w_wait_inc[7:0];
          end
          if (bus.branch_en) begin
            w_discard_nxt = 1'b1;
          end else if (w_timeout) begin
            // Abandoned request: the next fetch starts cleanly from r_pc.
            w_mem_req_nxt     = 1'b0;
            w_timeout_err_nxt = 1'b1;
            w_discard_nxt     = 1'b0;
          end
        end
      end
      c_HOLD: begin
        if (bus.branch_en) begin
          w_pc_nxt          = bus.branch_target;
          w_instr_valid_nxt = 1'b0;
        end else if (bus.instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          if (!bus.halt) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_pc;
            w_wait_cnt_nxt = 8'd0;
          end
        end
      end
      default: begin
        w_mem_req_nxt     = 1'b0;
        w_instr_valid_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_out   <= 16'd0;
      r_instr_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_discard     <= 1'b0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr_out   <= w_instr_out_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_discard     <= w_discard_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_out      = r_pc;
  assign bus.timeout_err = r_timeout_err;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;
  logic        w_fetch_done;

  // A fetch completes only when the word is actually delivered to HOLD.
  assign w_fetch_done = (r_state == c_WAIT) && bus.mem_ack && !r_discard &&
                        !bus.branch_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 16'd0;
      r_stall_count <= 16'd0;
    end else begin
      if (w_fetch_done && (r_fetch_count != 16'hFFFF)) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
      if (r_instr_valid && !bus.instr_ready && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.stall_count = r_stall_count;
`else
  assign bus.fetch_count = 16'd0;
  assign bus.stall_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Self-checking bench for instr_fetch_ctrl. A cycle-by-cycle
//                vector table covers fetch, stall, halt, branch/discard and PC
//                wrap; directed sequences cover async reset, zero-wait
//                streaming, a 5-cycle stall and the memory timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  logic clk;
  logic reset;
  logic auto_mode;
  logic man_ack;
  logic [15:0] man_rdata;

  int checks;
  int failures;
  int nv;
  int exp_fetch_tbl;
  int exp_stall_tbl;
  int exp_fetch_zw;
  int exp_stall_zw;
  int req_cycles;

  instr_fetch_ctrl_if #(.ADDR_W(16)) bus ();

  instr_fetch_ctrl #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .MAX_WAIT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: either zero-wait (ack whenever requested, data = addr^A5A5)
  // or driven manually by the stimulus.
  assign bus.mem_ack   = auto_mode ? bus.mem_req : man_ack;
  assign bus.mem_rdata = auto_mode ? (bus.mem_addr ^ 16'hA5A5) : man_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic        br;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic add(input logic h, input logic b, input logic [15:0] t,
                     input logic a, input logic [15:0] rd, input logic rdy,
                     input logic rq, input logic [15:0] ad, input logic v,
                     input logic [15:0] ins, input logic [15:0] p);
    vecs[nv] = '{h, b, t, a, rd, rdy, rq, ad, v, ins, p};
    nv++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; nv = 0;
    reset = 1'b1; auto_mode = 1'b0; man_ack = 1'b0; man_rdata = 16'h0;
    bus.halt = 1'b0; bus.branch_en = 1'b0; bus.branch_target = 16'h0;
    bus.instr_ready = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    exp_fetch_tbl = 6; exp_stall_tbl = 1; exp_fetch_zw = 3; exp_stall_zw = 5;
`else
    exp_fetch_tbl = 0; exp_stall_tbl = 0; exp_fetch_zw = 0; exp_stall_zw = 0;
`endif

    //   halt br tgt       ack rdata     rdy | req addr     vld instr     pc
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 16'h1111, 1,   0, 16'h0000, 1, 16'h1111, 16'h0001);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0001, 0, 16'h1111, 16'h0001);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0001, 0, 16'h1111, 16'h0001);
    add(0, 0, 16'h0000, 1, 16'h2222, 0,   0, 16'h0001, 1, 16'h2222, 16'h0002);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0001, 1, 16'h2222, 16'h0002);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0001, 0, 16'h2222, 16'h0002);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0001, 0, 16'h2222, 16'h0002);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h2222, 16'h0002);
    add(0, 1, 16'h0040, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h2222, 16'h0040);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h2222, 16'h0040);
    add(0, 1, 16'h0050, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h2222, 16'h0050);
    add(0, 0, 16'h0000, 1, 16'h1234, 1,   0, 16'h0002, 0, 16'h2222, 16'h0050);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0050, 0, 16'h2222, 16'h0050);
    add(0, 0, 16'h0000, 1, 16'hABCD, 0,   0, 16'h0050, 1, 16'hABCD, 16'h0051);
    add(0, 1, 16'h0080, 0, 16'h0000, 1,   0, 16'h0050, 0, 16'hABCD, 16'h0080);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0080, 0, 16'hABCD, 16'h0080);
    add(0, 1, 16'h0090, 1, 16'h5555, 1,   0, 16'h0080, 0, 16'hABCD, 16'h0090);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0090, 0, 16'hABCD, 16'h0090);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0090, 0, 16'hABCD, 16'h0090);
    add(1, 0, 16'h0000, 1, 16'h7777, 0,   0, 16'h0090, 1, 16'h7777, 16'h0091);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0090, 0, 16'h7777, 16'h0091);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0091, 0, 16'h7777, 16'h0091);
    add(0, 1, 16'hFFFF, 0, 16'h0000, 1,   1, 16'h0091, 0, 16'h7777, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'hDEAD, 1,   0, 16'h0091, 0, 16'h7777, 16'hFFFF);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'hFFFF, 0, 16'h7777, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'h0BEE, 1,   0, 16'hFFFF, 1, 16'h0BEE, 16'h0000);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0BEE, 16'h0000);
    add(0, 0, 16'h0000, 1, 16'h0001, 1,   0, 16'h0000, 1, 16'h0001, 16'h0001);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0001, 0, 16'h0001, 16'h0001);

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk("rst.req",   32'(bus.mem_req),     32'd0);
    chk("rst.addr",  32'(bus.mem_addr),    32'd0);
    chk("rst.valid", 32'(bus.instr_valid), 32'd0);
    chk("rst.instr", 32'(bus.instr_out),   32'd0);
    chk("rst.pc",    32'(bus.pc_out),      32'd0);
    chk("rst.terr",  32'(bus.timeout_err), 32'd0);
    chk("rst.fcnt",  32'(bus.fetch_count), 32'd0);
    chk("rst.scnt",  32'(bus.stall_count), 32'd0);
    reset = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < nv; i++) begin
      bus.halt          = vecs[i].halt;
      bus.branch_en     = vecs[i].br;
      bus.branch_target = vecs[i].tgt;
      man_ack           = vecs[i].ack;
      man_rdata         = vecs[i].rdata;
      bus.instr_ready   = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d.req", i),   32'(bus.mem_req),     32'(vecs[i].req));
      chk($sformatf("v%0d.addr", i),  32'(bus.mem_addr),    32'(vecs[i].addr));
      chk($sformatf("v%0d.valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d.instr", i), 32'(bus.instr_out),   32'(vecs[i].instr));
      chk($sformatf("v%0d.pc", i),    32'(bus.pc_out),      32'(vecs[i].pc));
      chk($sformatf("v%0d.terr", i),  32'(bus.timeout_err), 32'd0);
    end
    bus.branch_en = 1'b0; man_ack = 1'b0;
    chk("tbl.fcnt", 32'(bus.fetch_count), 32'(exp_fetch_tbl));
    chk("tbl.scnt", 32'(bus.stall_count), 32'(exp_stall_tbl));

    // ---------------- asynchronous reset with request in flight ----------------
    #2 reset = 1'b1;
    #1;
    chk("arst.req",   32'(bus.mem_req),     32'd0);
    chk("arst.valid", 32'(bus.instr_valid), 32'd0);
    chk("arst.pc",    32'(bus.pc_out),      32'd0);
    chk("arst.addr",  32'(bus.mem_addr),    32'd0);
    @(negedge clk);

    // ---------------- zero-wait streaming, then 5-cycle stall ----------------
    auto_mode = 1'b1; bus.halt = 1'b0; bus.instr_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("zw.c1.req",  32'(bus.mem_req),  32'd1);
    chk("zw.c1.addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk("zw.c2.valid", 32'(bus.instr_valid), 32'd1);
    chk("zw.c2.instr", 32'(bus.instr_out),   32'h0000A5A5);
    @(negedge clk);
    chk("zw.c3.valid", 32'(bus.instr_valid), 32'd0);
    chk("zw.c3.addr",  32'(bus.mem_addr),    32'd1);
    @(negedge clk);
    chk("zw.c4.valid", 32'(bus.instr_valid), 32'd1);
    chk("zw.c4.instr", 32'(bus.instr_out),   32'h0000A5A4);
    @(negedge clk);
    chk("zw.c5.valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    chk("zw.c6.valid", 32'(bus.instr_valid), 32'd1);
    chk("zw.c6.instr", 32'(bus.instr_out),   32'h0000A5A7);
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.valid", k), 32'(bus.instr_valid), 32'd1);
      chk($sformatf("stall%0d.instr", k), 32'(bus.instr_out),   32'h0000A5A7);
      chk($sformatf("stall%0d.req", k),   32'(bus.mem_req),     32'd0);
    end
    chk("stall.scnt", 32'(bus.stall_count), 32'(exp_stall_zw));
    chk("stall.fcnt", 32'(bus.fetch_count), 32'(exp_fetch_zw));
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("stall.resume.req",  32'(bus.mem_req),  32'd1);
    chk("stall.resume.addr", 32'(bus.mem_addr), 32'd3);

    // ---------------- memory timeout ----------------
    auto_mode = 1'b0; man_ack = 1'b0;
    pulse_reset();
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
      else if (req_cycles > 0) break;
    end
    chk("to.req_cycles", 32'(req_cycles),     32'd15);
    chk("to.req",        32'(bus.mem_req),     32'd0);
    chk("to.terr",       32'(bus.timeout_err), 32'd1);
    @(negedge clk);
    chk("to.retry.req",  32'(bus.mem_req),     32'd1);
    chk("to.retry.addr", 32'(bus.mem_addr),    32'd0);
    chk("to.retry.terr", 32'(bus.timeout_err), 32'd1);
    for (int k = 0; k < 14; k++) @(negedge clk);
    chk("to.wait14.req", 32'(bus.mem_req), 32'd1);
    // Acknowledge on the cycle that would otherwise time out.
    man_ack = 1'b1; man_rdata = 16'hC0DE;
    @(negedge clk);
    man_ack = 1'b0;
    chk("to.lastack.valid", 32'(bus.instr_valid), 32'd1);
    chk("to.lastack.instr", 32'(bus.instr_out),   32'h0000C0DE);
    chk("to.lastack.req",   32'(bus.mem_req),     32'd0);
    chk("to.lastack.terr",  32'(bus.timeout_err), 32'd1);

    // ---------------- sticky error clears only on reset ----------------
    pulse_reset();
    chk("to.clr.terr", 32'(bus.timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
